// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer in front of a word-addressed memory with decode errors and wait states.
// Defining APB_MEM_PSTRB_EN adds the pstrb port and byte-lane write masking.
module apb_mem_slave #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                pselx,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WCNT_W = 4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(WAIT_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                pready_d;
    logic                pslverr_d;
    logic [DATA_W-1:0]   prdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   off_word;
    logic [IDX_W-1:0]    idx;
    logic                err;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rsp_data;
    logic [DATA_W-1:0]   wr_word;
    logic [STRB_W-1:0]   strb_eff;
    logic                mem_we;

    // Address decode: offset from base, word index, range and alignment errors
    always_comb begin
        off      = paddr - BASE_ADDR;
        off_word = off >> LSB_W;
        idx      = off_word[IDX_W-1:0];
        err      = (paddr < BASE_ADDR) ||
                   (off_word >= DEPTH_A) ||
                   ((paddr & ALIGN_MASK) != '0);
    end

`ifdef APB_MEM_PSTRB_EN
    assign strb_eff = pstrb;
`else
    assign strb_eff = '1;
`endif

    assign rd_word  = mem[idx];
    assign rsp_data = (!pwrite && !err) ? rd_word : '0;

    // Merge enabled byte lanes of pwdata over the current word
    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb_eff[b]) begin
                wr_word[b*8 +: 8] = pwdata[b*8 +: 8];
            end
        end
    end

    // State and response registers
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    // Next state, wait counter and next response values
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        mem_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pselx && !penable) begin
                    state_d = S_ACCESS;
                    wcnt_d  = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = err;
                        prdata_d  = rsp_data;
                    end
                end
            end
            S_ACCESS: begin
                if (!pselx) begin
                    state_d   = S_IDLE;
                    wcnt_d    = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (!pready) begin
                    wcnt_d = (wcnt_q != '0) ? wcnt_q - WCNT_W'(1) : '0;
                    // Last wait state: the response becomes visible next cycle
                    if (wcnt_q <= WCNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = err;
                        prdata_d  = rsp_data;
                    end
                end else if (penable) begin
                    mem_we    = pwrite && !err;
                    state_d   = S_IDLE;
                    wcnt_d    = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory array is never reset; a reset edge suppresses a pending commit
    always_ff @(posedge pclk) begin
        if (presetn && mem_we) begin
            mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: drives one APB bus into a zero-wait and a three-wait instance of apb_mem_slave,
// scoreboarding responses against a reference memory model per instance.
module tb_apb_mem_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        pclk;
    logic        presetn;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb_drv;

    logic        pready0, pslverr0;
    logic [31:0] prdata0;
    logic        pready3, pslverr3;
    logic [31:0] prdata3;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_t        q0[$];
    rsp_t        q3[$];
    logic [31:0] mdl0[int];
    logic [31:0] mdl3[int];

    apb_mem_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)
    ) u_dut0 (
        .pclk(pclk), .presetn(presetn), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
        .pstrb(pstrb_drv),
`endif
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
    );

    apb_mem_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)
    ) u_dut3 (
        .pclk(pclk), .presetn(presetn), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
        .pstrb(pstrb_drv),
`endif
        .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || ((off >> 2) >= 32'(DEPTH)) || (a[1:0] != 2'b00);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        logic [3:0]  eff;
`ifdef APB_MEM_PSTRB_EN
        eff = strb;
`else
        eff = strb | 4'hF;
`endif
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (eff[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic drive_setup(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
        pselx     = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = data;
        pstrb_drv = strb;
    endtask

    // Full transfer held until the slower instance completes; checks pready timing of both
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic        e;
        int          i;
        rsp_t        r;
        logic [31:0] old0, old3;
        e = addr_err(addr);
        i = e ? 0 : addr_idx(addr);
        r.err  = e;
        r.data = (!wr && !e) ? mdl0[i] : 32'h0;
        q0.push_back(r);
        r.data = (!wr && !e) ? mdl3[i] : 32'h0;
        q3.push_back(r);
        drive_setup(wr, addr, data, strb);
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            check_val("pready0_cycle", 64'(pready0), 64'(k == 1));
            check_val("pready3_cycle", 64'(pready3), 64'(k == 4));
            @(posedge pclk); #1;
        end
        pselx   = 1'b0;
        penable = 1'b0;
        if (wr && !e) begin
            old0 = mdl0.exists(i) ? mdl0[i] : 32'h0;
            old3 = mdl3.exists(i) ? mdl3[i] : 32'h0;
            mdl0[i] = merge(old0, data, strb);
            mdl3[i] = merge(old3, data, strb);
        end
    endtask

    // Response monitor: pops the scoreboard whenever an instance completes
    always @(negedge pclk) begin
        rsp_t r;
        if (pready0 === 1'b1) begin
            if (q0.size() == 0) begin
                check_val("dut0_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                r = q0.pop_front();
                check_val("dut0_pslverr", 64'(pslverr0), 64'(r.err));
                check_val("dut0_prdata", 64'(prdata0), 64'(r.data));
            end
        end
        if (pready3 === 1'b1) begin
            if (q3.size() == 0) begin
                check_val("dut3_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                r = q3.pop_front();
                check_val("dut3_pslverr", 64'(pslverr3), 64'(r.err));
                check_val("dut3_prdata", 64'(prdata3), 64'(r.data));
            end
        end
    end

    initial begin
        rsp_t        r;
        logic [31:0] a, d;

        presetn = 1'b0;
        drive_setup(1'b0, BASE, 32'h0, 4'hF);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_val("rst_pready0", 64'(pready0), 64'd0);
        check_val("rst_prdata0", 64'(prdata0), 64'd0);
        check_val("rst_pslverr0", 64'(pslverr0), 64'd0);
        check_val("rst_pready3", 64'(pready3), 64'd0);
        check_val("rst_prdata3", 64'(prdata3), 64'd0);
        check_val("rst_pslverr3", 64'(pslverr3), 64'd0);
        presetn = 1'b1;
        pselx   = 1'b0;
        @(posedge pclk); #1;

        // Basic write / read-after-write
        apb_xfer(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF);
        apb_xfer(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF);
        apb_xfer(1'b0, 32'h1008, 32'h0, 4'hF);

        // Decode errors, then confirm word 0 survived
        apb_xfer(1'b0, 32'h0FFC, 32'h0, 4'hF);
        apb_xfer(1'b1, 32'h1002, 32'h5555_5555, 4'hF);
        apb_xfer(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
        apb_xfer(1'b0, 32'h1000, 32'h0, 4'hF);

        // Byte strobes (full-word write when the feature is off)
        apb_xfer(1'b1, 32'h1010, 32'hFFFF_FFFF, 4'hF);
        apb_xfer(1'b1, 32'h1010, 32'h1234_5678, 4'b0101);
        apb_xfer(1'b0, 32'h1010, 32'h0, 4'hF);
`ifdef APB_MEM_PSTRB_EN
        check_val("strb_model", 64'(mdl3[4]), 64'h0000_0000_FF34_FF78);
        apb_xfer(1'b1, 32'h1010, 32'hAAAA_AAAA, 4'b0000);
        apb_xfer(1'b0, 32'h1010, 32'h0, 4'hF);
`endif

        // Abort during a wait state: zero-wait instance already committed, the other must not
        apb_xfer(1'b1, 32'h1018, 32'h1111_2222, 4'hF);
        r.err  = 1'b0;
        r.data = 32'h0;
        q0.push_back(r);
        drive_setup(1'b1, 32'h1018, 32'hA5A5_A5A5, 4'hF);
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check_val("abort_pready3_a1", 64'(pready3), 64'd0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check_val("abort_pready3_a2", 64'(pready3), 64'd0);
        pselx   = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        check_val("abort_pready3", 64'(pready3), 64'd0);
        check_val("abort_prdata3", 64'(prdata3), 64'd0);
        check_val("abort_pslverr3", 64'(pslverr3), 64'd0);
        mdl0[6] = 32'hA5A5_A5A5;
        apb_xfer(1'b0, 32'h1018, 32'h0, 4'hF);

        // Reset asserted during the access phase of a write discards it
        r.err  = 1'b0;
        r.data = 32'h0;
        q0.push_back(r);
        drive_setup(1'b1, 32'h1000, 32'h9999_9999, 4'hF);
        @(posedge pclk); #1;
        penable = 1'b1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        pselx   = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        check_val("midrst_pready0", 64'(pready0), 64'd0);
        check_val("midrst_pready3", 64'(pready3), 64'd0);
        apb_xfer(1'b0, 32'h1000, 32'h0, 4'hF);

        // Random in-range write/read pairs
        for (int n = 0; n < 6; n++) begin
            a = BASE + 32'($urandom_range(8, DEPTH - 1) * 4);
            d = $urandom;
            apb_xfer(1'b1, a, d, 4'hF);
            apb_xfer(1'b0, a, 32'h0, 4'hF);
        end

        @(posedge pclk); #1;
        @(negedge pclk);
        check_val("q0_drained", 64'(q0.size()), 64'd0);
        check_val("q3_drained", 64'(q3.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
